// File: rtl/store_pkg.sv
// Shared encodings for the store narrowing path. The load-side extender uses the same size codes.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // Sub-word sizes that must go through read-modify-write and are naturally aligned.
    function automatic logic needsRmw(input size_t sz, input logic [1:0] off);
        return (sz == SZ_BYTE) || (sz == SZ_HALF && !off[0]);
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: overlays the low bytes of the store data onto the old memory word.
module store_lane_merge
    import store_pkg::*;
(
    input  logic [31:0] oldWord,
    input  logic [31:0] storeData,
    input  size_t       size,
    input  logic [1:0]  byteOff,
    output logic [31:0] mergedWord
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gLane
            logic       laneHit;
            logic [7:0] laneSrc;

            // Halfword stores feed byte gi%2 of the data into lane gi of the selected half.
            always_comb begin
                laneHit = 1'b0;
                laneSrc = storeData[8*gi +: 8];
                case (size)
                    SZ_BYTE: begin
                        laneHit = (byteOff == 2'(gi));
                        laneSrc = storeData[7:0];
                    end
                    SZ_HALF: begin
                        laneHit = (byteOff[1] == 1'(gi / 2));
                        laneSrc = storeData[8*(gi % 2) +: 8];
                    end
                    SZ_WORD: laneHit = 1'b1;
                    default: laneHit = 1'b0;
                endcase
            end

            assign mergedWord[8*gi +: 8] = laneHit ? laneSrc : oldWord[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing FSM: word stores write directly, sub-word stores read-modify-write,
// misaligned or illegal sizes are rejected without any memory strobe.
module store_narrow_unit
    import store_pkg::*;
#(
    parameter int ADDR_W = 30
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              done,
    output logic              misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_wack
);

    state_t            stateReg, stateNext;
    logic [ADDR_W-1:0] addrReg;
    logic [1:0]        offReg;
    logic [31:0]       dataReg;
    size_t             sizeReg;
    logic [31:0]       wdataReg;
    logic [31:0]       mergedWord;

    size_t reqSize;
    logic  directWrite;
    assign reqSize     = size_t'(req_size);
    assign directWrite = (reqSize == SZ_WORD) && (req_addr[1:0] == 2'b00);

    store_lane_merge uMerge (
        .oldWord    (mem_rdata),
        .storeData  (dataReg),
        .size       (sizeReg),
        .byteOff    (offReg),
        .mergedWord (mergedWord)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stateReg <= ST_IDLE;
            addrReg  <= '0;
            offReg   <= '0;
            dataReg  <= '0;
            sizeReg  <= SZ_BYTE;
            wdataReg <= '0;
        end else begin
            stateReg <= stateNext;
            if (stateReg == ST_IDLE && req_valid) begin
                addrReg <= req_addr[ADDR_W+1:2];
                offReg  <= req_addr[1:0];
                dataReg <= req_data;
                sizeReg <= reqSize;
                if (directWrite)
                    wdataReg <= req_data;
            end else if (stateReg == ST_READ && mem_rvalid) begin
                wdataReg <= mergedWord;
            end
        end
    end

    // Strobes decode straight from the state register so an async reset drops them at once.
    always_comb begin
        stateNext  = stateReg;
        req_ready  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        done       = 1'b0;
        misaligned = 1'b0;
        case (stateReg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (directWrite)
                        stateNext = ST_WRITE;
                    else if (needsRmw(reqSize, req_addr[1:0]))
                        stateNext = ST_READ;
                    else
                        stateNext = ST_ERR;
                end
            end
            ST_READ: begin
                mem_rd = 1'b1;
                if (mem_rvalid)
                    stateNext = ST_WRITE;
            end
            ST_WRITE: begin
                mem_wr = 1'b1;
                if (mem_wack)
                    stateNext = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                stateNext = ST_IDLE;
            end
            ST_ERR: begin
                done       = 1'b1;
                misaligned = 1'b1;
                stateNext  = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    assign mem_addr  = addrReg;
    assign mem_wdata = wdataReg;

endmodule
